// File: rtl/axi_slv_pkg.sv
// Shared constants and derived-width helpers for the AXI slave write framer.
package axi_slv_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Frame layout, MSB first: {awlen, eof, sof, write flag, payload, frame address}
  localparam int unsigned FRM_LEN_W  = 8;
  localparam int unsigned FRM_FLAG_W = 3;

  function automatic int unsigned calc_fa_w(input int unsigned addr_w,
                                            input int unsigned frame_dw);
    return addr_w - $clog2(frame_dw / 8);
  endfunction

  function automatic int unsigned calc_frame_w(input int unsigned frame_dw,
                                               input int unsigned fa_w);
    return FRM_LEN_W + FRM_FLAG_W + frame_dw + fa_w;
  endfunction

  function automatic int unsigned calc_ratio_lg(input int unsigned wide_w,
                                                input int unsigned narrow_w);
    return $clog2(wide_w / narrow_w);
  endfunction

endpackage

// File: rtl/sync_fifo_w2n.sv
// Wide-in / narrow-out first-word-fall-through FIFO; each entry is read
// DATA_WIDTH_I/DATA_WIDTH_O times, least-significant slice first.
module sync_fifo_w2n
  import axi_slv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_I = 256,
  parameter int unsigned DATA_WIDTH_O = 64,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH_I-1:0] wr_data,
  output logic                    full_c,
  input  logic                    rd_en,
  output logic [DATA_WIDTH_O-1:0] rd_data_c,
  output logic                    empty_c
);

  localparam int unsigned R  = DATA_WIDTH_I / DATA_WIDTH_O;
  localparam int unsigned RS = calc_ratio_lg(DATA_WIDTH_I, DATA_WIDTH_O);
  localparam int unsigned SW = (RS > 0) ? RS : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH_I-1:0]            mem [FIFO_DEPTH];
  logic [AW:0]                        wr_ptr;
  logic [AW:0]                        rd_ptr;
  logic [SW-1:0]                      slice;
  logic [R-1:0][DATA_WIDTH_O-1:0]     head;
  logic                               slice_last;

  assign empty_c    = (wr_ptr == rd_ptr);
  assign full_c     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign rd_data_c  = head[slice];
  assign slice_last = (slice == SW'(R - 1));

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !full_c) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      slice  <= '0;
    end else begin
      if (wr_en && !full_c) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty_c) begin
        if (slice_last) begin
          slice  <= '0;
          rd_ptr <= rd_ptr + (AW+1)'(1);
        end else begin
          slice  <= slice + SW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/axi_slv_wr_framer.sv
// AXI slave write front end: one AW+W burst at a time, W beats sliced into
// narrow frames with row-boundary sof/eof markers, B response after last frame.
module axi_slv_wr_framer
  import axi_slv_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH   = 256,
  parameter int unsigned FRAME_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH   = 25,
  parameter int unsigned ID_WIDTH         = 4,
  parameter int unsigned COL_BITS         = 6,
  parameter int unsigned FIFO_DEPTH       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      axi_s_awvalid,
  output logic                      axi_s_awready,
  input  logic [ID_WIDTH-1:0]       axi_s_awid,
  input  logic [7:0]                axi_s_awlen,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_s_awaddr,
  input  logic                      axi_s_wvalid,
  output logic                      axi_s_wready,
  input  logic                      axi_s_wlast,
  input  logic [AXI_DATA_WIDTH-1:0] axi_s_wdata,
  output logic                      axi_s_bvalid,
  input  logic                      axi_s_bready,
  output logic [ID_WIDTH-1:0]       axi_s_bid,
  output logic [1:0]                axi_s_bresp,
  output logic                      axi2arb_wframe_valid,
  input  logic                      axi2arb_wframe_ready,
  output logic [calc_frame_w(FRAME_DATA_WIDTH,
                calc_fa_w(AXI_ADDR_WIDTH, FRAME_DATA_WIDTH))-1:0] axi2arb_wframe_data
);

  localparam int unsigned RS      = calc_ratio_lg(AXI_DATA_WIDTH, FRAME_DATA_WIDTH);
  localparam int unsigned BO      = $clog2(FRAME_DATA_WIDTH / 8);
  localparam int unsigned FA_W    = calc_fa_w(AXI_ADDR_WIDTH, FRAME_DATA_WIDTH);
  localparam int unsigned CNT_W   = 8 + RS + 1;

  logic [1:0]                  state_q, state_d;
  logic [FA_W-1:0]             fa_q;
  logic [7:0]                  len_q;
  logic [ID_WIDTH-1:0]         id_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        fifo_full_c, fifo_empty_c;
  logic [FRAME_DATA_WIDTH-1:0] fifo_data_c;
  logic                        aw_hs, w_hs, f_hs, b_hs;
  logic                        last_c, sof_c, eof_c;
  logic                        unused_c;

  assign unused_c = ^{axi_s_wlast, axi_s_awaddr[BO-1:0]};

  assign axi_s_awready        = (state_q == ST_IDLE);
  assign axi_s_wready         = !fifo_full_c;
  assign axi_s_bvalid         = (state_q == ST_RESP);
  assign axi_s_bid            = id_q;
  assign axi_s_bresp          = RESP_OKAY;
  assign axi2arb_wframe_valid = (state_q == ST_DATA) && !fifo_empty_c;

  assign aw_hs = axi_s_awvalid && axi_s_awready;
  assign w_hs  = axi_s_wvalid && axi_s_wready;
  assign f_hs  = axi2arb_wframe_valid && axi2arb_wframe_ready;
  assign b_hs  = axi_s_bvalid && axi_s_bready;

  // Last frame of the burst is frame (awlen+1)*R - 1.
  assign last_c = (cnt_q == (((CNT_W'(len_q) + CNT_W'(1)) << RS) - CNT_W'(1)));
  assign sof_c  = (cnt_q == '0) || (fa_q[COL_BITS-1:0] == '0);
  assign eof_c  = (fa_q[COL_BITS-1:0] == '1) || last_c;

  assign axi2arb_wframe_data = {len_q, eof_c, sof_c, 1'b1, fifo_data_c, fa_q};

  sync_fifo_w2n #(
    .DATA_WIDTH_I (AXI_DATA_WIDTH),
    .DATA_WIDTH_O (FRAME_DATA_WIDTH),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (w_hs),
    .wr_data   (axi_s_wdata),
    .full_c    (fifo_full_c),
    .rd_en     (f_hs),
    .rd_data_c (fifo_data_c),
    .empty_c   (fifo_empty_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (aw_hs)           state_d = ST_DATA;
      ST_DATA: if (f_hs && last_c)  state_d = ST_RESP;
      ST_RESP: if (b_hs)            state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Burst context: captured on AW, advanced per accepted frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fa_q  <= '0;
      len_q <= '0;
      id_q  <= '0;
      cnt_q <= '0;
    end else if (aw_hs) begin
      fa_q  <= axi_s_awaddr[AXI_ADDR_WIDTH-1:BO];
      len_q <= axi_s_awlen;
      id_q  <= axi_s_awid;
      cnt_q <= '0;
    end else if (f_hs) begin
      fa_q  <= fa_q + FA_W'(1);
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axi_slv_wr_framer.sv
// Directed bench for axi_slv_wr_framer at default parameters (97-bit frames).
module tb_axi_slv_wr_framer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         awvalid, awready;
  logic [3:0]   awid;
  logic [7:0]   awlen;
  logic [24:0]  awaddr;
  logic         wvalid, wready, wlast;
  logic [255:0] wdata;
  logic         bvalid, bready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         fvalid, fready;
  logic [96:0]  fdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_slv_wr_framer dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .axi_s_awvalid        (awvalid),
    .axi_s_awready        (awready),
    .axi_s_awid           (awid),
    .axi_s_awlen          (awlen),
    .axi_s_awaddr         (awaddr),
    .axi_s_wvalid         (wvalid),
    .axi_s_wready         (wready),
    .axi_s_wlast          (wlast),
    .axi_s_wdata          (wdata),
    .axi_s_bvalid         (bvalid),
    .axi_s_bready         (bready),
    .axi_s_bid            (bid),
    .axi_s_bresp          (bresp),
    .axi2arb_wframe_valid (fvalid),
    .axi2arb_wframe_ready (fready),
    .axi2arb_wframe_data  (fdata)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pl(input int k);
    return {32'hC0DE_F00D, 32'(k)};
  endfunction

  function automatic logic [255:0] mk_beat(input int k0);
    return {pl(k0 + 3), pl(k0 + 2), pl(k0 + 1), pl(k0)};
  endfunction

  // All tasks start and end at a falling edge.
  task automatic push_w(input logic [255:0] d);
    int n = 0;
    wvalid = 1'b1;
    wdata  = d;
    while (!wready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("w_accept", 128'(wready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [24:0] a, input logic [7:0] l, input logic [3:0] id);
    int n = 0;
    awvalid = 1'b1;
    awaddr  = a;
    awlen   = l;
    awid    = id;
    while (!awready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("aw_accept", 128'(awready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [21:0] fa, input logic [7:0] l,
                              input logic [63:0] p, input logic sof, input logic eof);
    int n = 0;
    fready = 1'b1;
    while (!fvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 128'(fvalid), 128'(1));
    check(tag, 128'(fdata), 128'({l, eof, sof, 1'b1, p, fa}));
    @(posedge clk);
    @(negedge clk);
    fready = 1'b0;
  endtask

  task automatic expect_bresp(input logic [3:0] id);
    check("bvalid", 128'(bvalid), 128'(1));
    check("bid", 128'(bid), 128'(id));
    check("bresp", 128'(bresp), 128'(0));
    check("fvalid_after_last", 128'(fvalid), 128'(0));
    check("awready_in_resp", 128'(awready), 128'(0));
  endtask

  task automatic b_handshake();
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_cleared", 128'(bvalid), 128'(0));
    check("awready_back", 128'(awready), 128'(1));
  endtask

  initial begin
    logic [7:0] sof_m;
    logic [7:0] eof_m;
    int nb;

    rst_n = 1'b0; awvalid = 1'b0; awid = '0; awlen = '0; awaddr = '0;
    wvalid = 1'b0; wlast = 1'b0; wdata = '0; bready = 1'b0; fready = 1'b0;
    #1;
    check("rst_awready", 128'(awready), 128'(1));
    check("rst_wready", 128'(wready), 128'(1));
    check("rst_fvalid", 128'(fvalid), 128'(0));
    check("rst_bvalid", 128'(bvalid), 128'(0));
    check("rst_bid", 128'(bid), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single beat at address 0
    push_w(mk_beat(0));
    send_aw(25'h0, 8'd0, 4'd5);
    expect_frame("t1_f0", 22'd0, 8'd0, pl(0), 1'b1, 1'b0);
    expect_frame("t1_f1", 22'd1, 8'd0, pl(1), 1'b0, 1'b0);
    expect_frame("t1_f2", 22'd2, 8'd0, pl(2), 1'b0, 1'b0);
    expect_frame("t1_f3", 22'd3, 8'd0, pl(3), 1'b0, 1'b1);
    expect_bresp(4'd5);
    b_handshake();

    // Row crossing: frames 61..68
    push_w(mk_beat(20));
    push_w(mk_beat(24));
    send_aw(25'h1E8, 8'd1, 4'd7);
    sof_m = 8'b0000_1001;
    eof_m = 8'b1000_0100;
    for (int f = 0; f < 8; f++)
      expect_frame("t2_frame", 22'(61 + f), 8'd1, pl(20 + f), sof_m[f], eof_m[f]);
    expect_bresp(4'd7);
    b_handshake();

    // Arbiter stall and W starvation mid-burst
    push_w(mk_beat(100));
    send_aw(25'h100, 8'd1, 4'd2);
    expect_frame("t3_f0", 22'd32, 8'd1, pl(100), 1'b1, 1'b0);
    expect_frame("t3_f1", 22'd33, 8'd1, pl(101), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("t3_stall_valid", 128'(fvalid), 128'(1));
      check("t3_stall_hold", 128'(fdata), 128'({8'd1, 1'b0, 1'b0, 1'b1, pl(102), 22'd34}));
      @(negedge clk);
    end
    expect_frame("t3_f2", 22'd34, 8'd1, pl(102), 1'b0, 1'b0);
    expect_frame("t3_f3", 22'd35, 8'd1, pl(103), 1'b0, 1'b0);
    fready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_empty_valid", 128'(fvalid), 128'(0));
      check("t3_empty_addr", 128'(fdata[21:0]), 128'(36));
      @(negedge clk);
    end
    fready = 1'b0;
    push_w(mk_beat(104));
    for (int f = 4; f < 8; f++)
      expect_frame("t3_frame", 22'(32 + f), 8'd1, pl(100 + f), 1'b0, f == 7);
    expect_bresp(4'd2);
    b_handshake();
    check("t3_no_extra", 128'(fvalid), 128'(0));

    // Ten beats ahead of AW: FIFO fills at eight
    for (int b = 0; b < 8; b++) push_w(mk_beat(200 + 4 * b));
    wvalid = 1'b1;
    wdata  = mk_beat(232);
    for (int i = 0; i < 3; i++) begin
      check("t4_full_wready", 128'(wready), 128'(0));
      @(negedge clk);
    end
    wvalid = 1'b0;
    send_aw(25'h0, 8'd9, 4'd3);
    nb = 8;
    for (int f = 0; f < 40; f++) begin
      expect_frame("t4_frame", 22'(f), 8'd9, pl(200 + f), f == 0, f == 39);
      if ((f % 4) == 3 && nb < 10) begin
        push_w(mk_beat(200 + 4 * nb));
        nb++;
      end
    end
    expect_bresp(4'd3);
    b_handshake();

    // B back-pressure with next-burst data waiting
    push_w(mk_beat(300));
    send_aw(25'h3F8, 8'd0, 4'd11);
    expect_frame("t5_f0", 22'd127, 8'd0, pl(300), 1'b1, 1'b1);
    expect_frame("t5_f1", 22'd128, 8'd0, pl(301), 1'b1, 1'b0);
    expect_frame("t5_f2", 22'd129, 8'd0, pl(302), 1'b0, 1'b0);
    expect_frame("t5_f3", 22'd130, 8'd0, pl(303), 1'b0, 1'b1);
    expect_bresp(4'd11);
    push_w(mk_beat(400));
    fready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_bvalid_hold", 128'(bvalid), 128'(1));
      check("t5_awready_low", 128'(awready), 128'(0));
      check("t5_no_frame", 128'(fvalid), 128'(0));
      @(negedge clk);
    end
    fready = 1'b0;
    b_handshake();

    // Reset at frame 2 of a burst, then a clean burst
    send_aw(25'h40, 8'd0, 4'd6);
    expect_frame("t6_f0", 22'd8, 8'd0, pl(400), 1'b1, 1'b0);
    expect_frame("t6_f1", 22'd9, 8'd0, pl(401), 1'b0, 1'b0);
    check("t6_pre_rst_valid", 128'(fvalid), 128'(1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_fvalid", 128'(fvalid), 128'(0));
    check("t6_rst_awready", 128'(awready), 128'(1));
    check("t6_rst_bvalid", 128'(bvalid), 128'(0));
    check("t6_rst_bid", 128'(bid), 128'(0));
    check("t6_rst_wready", 128'(wready), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_bvalid", 128'(bvalid), 128'(0));
    push_w(mk_beat(500));
    send_aw(25'h0, 8'd0, 4'd9);
    expect_frame("t6_g0", 22'd0, 8'd0, pl(500), 1'b1, 1'b0);
    expect_frame("t6_g1", 22'd1, 8'd0, pl(501), 1'b0, 1'b0);
    expect_frame("t6_g2", 22'd2, 8'd0, pl(502), 1'b0, 1'b0);
    expect_frame("t6_g3", 22'd3, 8'd0, pl(503), 1'b0, 1'b1);
    expect_bresp(4'd9);
    b_handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
